// File: rtl/div_operand_join.sv
// rtl/div_operand_join.sv - joins dividend/divisor streams into aligned operand pairs for the divider
module div_operand_join #(
    parameter int XLEN  = 16,
    parameter int DEPTH = 4,
    parameter int ZDROP = 1,
    parameter int CNTW  = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [XLEN-1:0]            s1_tdata_i,
    input  logic                       s1_tvalid_i,
    output logic                       s1_tready_o,
    input  logic [XLEN-1:0]            s2_tdata_i,
    input  logic                       s2_tvalid_i,
    output logic                       s2_tready_o,
    output logic [XLEN-1:0]            m1_tdata_o,
    output logic                       m1_tvalid_o,
    input  logic                       m1_tready_i,
    output logic [XLEN-1:0]            m2_tdata_o,
    output logic                       m2_tvalid_o,
    input  logic                       m2_tready_i,
    output logic [$clog2(DEPTH+1)-1:0] lvl1_o,
    output logic [$clog2(DEPTH+1)-1:0] lvl2_o,
    output logic [CNTW-1:0]            zdiv_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [XLEN-1:0] mem1_q [DEPTH];
    logic [XLEN-1:0] mem2_q [DEPTH];
    logic [AW-1:0]   wptr1_q, wptr1_d, rptr1_q, rptr1_d;
    logic [AW-1:0]   wptr2_q, wptr2_d, rptr2_q, rptr2_d;
    logic [LW-1:0]   lvl1_q, lvl1_d, lvl2_q, lvl2_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            push1, push2, both, zhead, vld, pop;

    assign s1_tready_o = !rst_i && (lvl1_q != LW'(DEPTH));
    assign s2_tready_o = !rst_i && (lvl2_q != LW'(DEPTH));
    assign push1 = s1_tvalid_i && s1_tready_o;
    assign push2 = s2_tvalid_i && s2_tready_o;

    // A zero-divisor head pops both FIFOs without ever being offered downstream.
    assign both  = (lvl1_q != '0) && (lvl2_q != '0);
    assign zhead = (ZDROP != 0) && both && (mem2_q[rptr2_q] == '0);
    assign vld   = both && !zhead;
    assign pop   = (vld && m1_tready_i && m2_tready_i) || zhead;

    assign m1_tvalid_o = vld;
    assign m2_tvalid_o = vld;
    assign m1_tdata_o  = mem1_q[rptr1_q];
    assign m2_tdata_o  = mem2_q[rptr2_q];
    assign lvl1_o      = lvl1_q;
    assign lvl2_o      = lvl2_q;
    assign zdiv_cnt_o  = cnt_q;

    always_comb begin
        wptr1_d = push1 ? wptr1_q + AW'(1) : wptr1_q;
        wptr2_d = push2 ? wptr2_q + AW'(1) : wptr2_q;
        rptr1_d = pop ? rptr1_q + AW'(1) : rptr1_q;
        rptr2_d = pop ? rptr2_q + AW'(1) : rptr2_q;
        lvl1_d  = lvl1_q;
        lvl2_d  = lvl2_q;
        if (push1 && !pop) lvl1_d = lvl1_q + LW'(1);
        else if (!push1 && pop) lvl1_d = lvl1_q - LW'(1);
        if (push2 && !pop) lvl2_d = lvl2_q + LW'(1);
        else if (!push2 && pop) lvl2_d = lvl2_q - LW'(1);
        cnt_d = (zhead && (cnt_q != '1)) ? cnt_q + CNTW'(1) : cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr1_q <= '0;
            rptr1_q <= '0;
            wptr2_q <= '0;
            rptr2_q <= '0;
            lvl1_q  <= '0;
            lvl2_q  <= '0;
            cnt_q   <= '0;
        end else begin
            wptr1_q <= wptr1_d;
            rptr1_q <= rptr1_d;
            wptr2_q <= wptr2_d;
            rptr2_q <= rptr2_d;
            lvl1_q  <= lvl1_d;
            lvl2_q  <= lvl2_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage is deliberately left out of reset; occupancy alone defines what is valid.
    always_ff @(posedge clk_i) begin
        if (push1) mem1_q[wptr1_q] <= s1_tdata_i;
        if (push2) mem2_q[wptr2_q] <= s2_tdata_i;
    end
endmodule

// File: tb/tb_div_operand_join.sv
// tb/tb_div_operand_join.sv - scoreboard bench for div_operand_join (ZDROP=1 and ZDROP=0 instances)
module tb_div_operand_join;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s1_tdata, s2_tdata;
    logic        s1_tvalid, s2_tvalid, m1_tready, m2_tready;
    logic        s1_tready, s2_tready, m1_tvalid, m2_tvalid;
    logic [15:0] m1_tdata, m2_tdata;
    logic [2:0]  lvl1, lvl2;
    logic [7:0]  zcnt;
    logic        b_s1_tready, b_s2_tready, b_m1_tvalid, b_m2_tvalid;
    logic [15:0] b_m1_tdata, b_m2_tdata;
    logic [2:0]  b_lvl1, b_lvl2;
    logic [7:0]  b_zcnt;

    int tests = 0;
    int fails = 0;
    logic [31:0] q[$];
    logic [31:0] q0[$];
    logic [31:0] exp_m, exp_b;

    always #5 clk = ~clk;

    div_operand_join #(.XLEN(16), .DEPTH(4), .ZDROP(1), .CNTW(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .s1_tdata_i(s1_tdata), .s1_tvalid_i(s1_tvalid), .s1_tready_o(s1_tready),
        .s2_tdata_i(s2_tdata), .s2_tvalid_i(s2_tvalid), .s2_tready_o(s2_tready),
        .m1_tdata_o(m1_tdata), .m1_tvalid_o(m1_tvalid), .m1_tready_i(m1_tready),
        .m2_tdata_o(m2_tdata), .m2_tvalid_o(m2_tvalid), .m2_tready_i(m2_tready),
        .lvl1_o(lvl1), .lvl2_o(lvl2), .zdiv_cnt_o(zcnt)
    );

    div_operand_join #(.XLEN(16), .DEPTH(4), .ZDROP(0), .CNTW(8)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .s1_tdata_i(s1_tdata), .s1_tvalid_i(s1_tvalid), .s1_tready_o(b_s1_tready),
        .s2_tdata_i(s2_tdata), .s2_tvalid_i(s2_tvalid), .s2_tready_o(b_s2_tready),
        .m1_tdata_o(b_m1_tdata), .m1_tvalid_o(b_m1_tvalid), .m1_tready_i(m1_tready),
        .m2_tdata_o(b_m2_tdata), .m2_tvalid_o(b_m2_tvalid), .m2_tready_i(m2_tready),
        .lvl1_o(b_lvl1), .lvl2_o(b_lvl2), .zdiv_cnt_o(b_zcnt)
    );

    // Output monitors: every transfer must match the head of its scoreboard.
    always @(negedge clk) begin
        if (m1_tvalid === 1'b1 && m1_tready && m2_tready) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL out_unexpected got %h/%h required none", m1_tdata, m2_tdata);
            end else begin
                exp_m = q.pop_front();
                if ({m1_tdata, m2_tdata} !== exp_m || m2_tvalid !== 1'b1) begin
                    fails++;
                    $display("FAIL out_pair got %h/%h v2=%b required %h/%h v2=1",
                             m1_tdata, m2_tdata, m2_tvalid, exp_m[31:16], exp_m[15:0]);
                end
            end
        end
        if (b_m1_tvalid === 1'b1 && m1_tready && m2_tready) begin
            tests++;
            if (q0.size() == 0) begin
                fails++;
                $display("FAIL out0_unexpected got %h/%h required none", b_m1_tdata, b_m2_tdata);
            end else begin
                exp_b = q0.pop_front();
                if ({b_m1_tdata, b_m2_tdata} !== exp_b) begin
                    fails++;
                    $display("FAIL out0_pair got %h/%h required %h/%h",
                             b_m1_tdata, b_m2_tdata, exp_b[31:16], exp_b[15:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_s1(input logic [15:0] d);
        int n = 0;
        s1_tdata = d; s1_tvalid = 1'b1;
        @(negedge clk);
        while (s1_tready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin fails++; $display("FAIL push_s1_timeout got ready=%b required 1", s1_tready); end
        step();
        s1_tvalid = 1'b0;
    endtask

    task automatic push_s2(input logic [15:0] d);
        int n = 0;
        s2_tdata = d; s2_tvalid = 1'b1;
        @(negedge clk);
        while (s2_tready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin fails++; $display("FAIL push_s2_timeout got ready=%b required 1", s2_tready); end
        step();
        s2_tvalid = 1'b0;
    endtask

    task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        s1_tdata = a; s2_tdata = b; s1_tvalid = 1'b1; s2_tvalid = 1'b1;
        @(negedge clk);
        while (!(s1_tready === 1'b1 && s2_tready === 1'b1) && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin fails++; $display("FAIL push_pair_timeout got ready=%b%b required 11", s1_tready, s2_tready); end
        step();
        s1_tvalid = 1'b0; s2_tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && (q.size() != 0 || q0.size() != 0); i++) @(negedge clk);
        tests++;
        if (q.size() != 0 || q0.size() != 0) begin
            fails++;
            $display("FAIL %s_drain got pending=%0d/%0d required 0/0", name, q.size(), q0.size());
        end
        step();
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if (s1_tready !== 1'b0 || s2_tready !== 1'b0) begin
            fails++; $display("FAIL reset_tready got %b%b required 00", s1_tready, s2_tready);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (lvl1 !== 3'd0 || lvl2 !== 3'd0 || m1_tvalid !== 1'b0 || zcnt !== 8'd0) begin
            fails++; $display("FAIL reset_state got lvl=%0d/%0d v=%b z=%0d required 0/0 0 0", lvl1, lvl2, m1_tvalid, zcnt);
        end
        tests++;
        if (s1_tready !== 1'b1 || s2_tready !== 1'b1) begin
            fails++; $display("FAIL reset_release_tready got %b%b required 11", s1_tready, s2_tready);
        end
        step();
    endtask

    task automatic test_single_pair();
        push_s1(16'h0064);
        step(); step();
        q.push_back({16'h0064, 16'h0007});
        q0.push_back({16'h0064, 16'h0007});
        push_s2(16'h0007);
        @(negedge clk);
        tests++;
        if (m1_tvalid !== 1'b1 || m2_tvalid !== 1'b1 || m1_tdata !== 16'h0064 || m2_tdata !== 16'h0007) begin
            fails++; $display("FAIL single_latency got v=%b%b %h/%h required 11 0064/0007", m1_tvalid, m2_tvalid, m1_tdata, m2_tdata);
        end
        step();
        @(negedge clk);
        tests++;
        if (lvl1 !== 3'd0 || lvl2 !== 3'd0 || m1_tvalid !== 1'b0) begin
            fails++; $display("FAIL single_empty got lvl=%0d/%0d v=%b required 0/0 0", lvl1, lvl2, m1_tvalid);
        end
        step();
    endtask

    task automatic test_skew_full();
        for (int i = 1; i <= 4; i++) push_s1(16'(i));
        @(negedge clk);
        tests++;
        if (lvl1 !== 3'd4 || s1_tready !== 1'b0 || s2_tready !== 1'b1 || m1_tvalid !== 1'b0) begin
            fails++; $display("FAIL skew_full got lvl1=%0d rdy=%b%b v=%b required 4 01 0", lvl1, s1_tready, s2_tready, m1_tvalid);
        end
        step();
        for (int i = 1; i <= 4; i++) begin
            q.push_back({16'(i), 16'(i + 4)});
            q0.push_back({16'(i), 16'(i + 4)});
        end
        for (int i = 5; i <= 8; i++) push_s2(16'(i));
        drain("skew");
    endtask

    task automatic test_zero_drop();
        q.push_back({16'd10, 16'd2});
        q.push_back({16'd13, 16'd3});
        q0.push_back({16'd10, 16'd2});
        q0.push_back({16'd11, 16'd0});
        q0.push_back({16'd12, 16'd0});
        q0.push_back({16'd13, 16'd3});
        push_pair(16'd10, 16'd2);
        push_pair(16'd11, 16'd0);
        push_pair(16'd12, 16'd0);
        push_pair(16'd13, 16'd3);
        drain("zero");
        @(negedge clk);
        tests++;
        if (zcnt !== 8'd2) begin
            fails++; $display("FAIL zero_count got %0d required 2", zcnt);
        end
        tests++;
        if (b_zcnt !== 8'd0) begin
            fails++; $display("FAIL zero_count_nodrop got %0d required 0", b_zcnt);
        end
        step();
    endtask

    task automatic test_backpressure();
        m1_tready = 1'b1; m2_tready = 1'b0;
        q.push_back({16'hFF9C, 16'h0005});
        q0.push_back({16'hFF9C, 16'h0005});
        push_pair(16'hFF9C, 16'h0005);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (m1_tvalid !== 1'b1 || m1_tdata !== 16'hFF9C || m2_tdata !== 16'h0005 || lvl1 !== 3'd1 || lvl2 !== 3'd1) begin
                fails++; $display("FAIL bp_hold got v=%b %h/%h lvl=%0d/%0d required 1 ff9c/0005 1/1", m1_tvalid, m1_tdata, m2_tdata, lvl1, lvl2);
            end
            step();
        end
        m2_tready = 1'b1;
        drain("bp");
        @(negedge clk);
        tests++;
        if (lvl1 !== 3'd0 || lvl2 !== 3'd0) begin
            fails++; $display("FAIL bp_release got lvl=%0d/%0d required 0/0", lvl1, lvl2);
        end
        step();
    endtask

    task automatic test_back_to_back();
        m1_tready = 1'b0; m2_tready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            q.push_back({16'(100 + i), 16'(16'h200 + i)});
            q0.push_back({16'(100 + i), 16'(16'h200 + i)});
            push_pair(16'(100 + i), 16'(16'h200 + i));
        end
        m1_tready = 1'b1; m2_tready = 1'b1;
        s1_tvalid = 1'b1; s2_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s1_tdata = 16'(102 + i);
            s2_tdata = 16'(16'h202 + i);
            q.push_back({s1_tdata, s2_tdata});
            q0.push_back({s1_tdata, s2_tdata});
            @(negedge clk);
            tests++;
            if (lvl1 !== 3'd2 || lvl2 !== 3'd2 || s1_tready !== 1'b1 || s2_tready !== 1'b1) begin
                fails++; $display("FAIL stream_level cycle %0d got lvl=%0d/%0d rdy=%b%b required 2/2 11", i, lvl1, lvl2, s1_tready, s2_tready);
            end
            step();
        end
        s1_tvalid = 1'b0; s2_tvalid = 1'b0;
        drain("stream");
    endtask

    task automatic test_reset_mid();
        m1_tready = 1'b0; m2_tready = 1'b0;
        push_s1(16'h0030); push_s1(16'h0031); push_s1(16'h0032);
        push_s2(16'h0009);
        @(negedge clk);
        tests++;
        if (lvl1 !== 3'd3 || lvl2 !== 3'd1) begin
            fails++; $display("FAIL rmid_pre got lvl=%0d/%0d required 3/1", lvl1, lvl2);
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (s1_tready !== 1'b0 || s2_tready !== 1'b0) begin
            fails++; $display("FAIL rmid_tready got %b%b required 00", s1_tready, s2_tready);
        end
        step();
        rst = 1'b0;
        q.delete(); q0.delete();
        @(negedge clk);
        tests++;
        if (lvl1 !== 3'd0 || lvl2 !== 3'd0 || m1_tvalid !== 1'b0 || zcnt !== 8'd0) begin
            fails++; $display("FAIL rmid_state got lvl=%0d/%0d v=%b z=%0d required 0/0 0 0", lvl1, lvl2, m1_tvalid, zcnt);
        end
        step();
        m1_tready = 1'b1; m2_tready = 1'b1;
        q.push_back({16'd5, 16'd1});
        q0.push_back({16'd5, 16'd1});
        push_pair(16'd5, 16'd1);
        drain("rmid");
    endtask

    initial begin
        rst = 1'b1;
        s1_tdata = '0; s2_tdata = '0;
        s1_tvalid = 1'b0; s2_tvalid = 1'b0;
        m1_tready = 1'b1; m2_tready = 1'b1;
        step(); step();
        test_reset();
        test_single_pair();
        test_skew_full();
        test_zero_drop();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
